// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters (CPU, debug/loader), the arbiter and the memory port.
// The arbiter connects through 'slave' (it serves the masters); the environment uses 'master'.
interface bus_arbiter_if;
   logic [15:0] m0_addr;
   logic [7:0]  m0_wdata;
   logic        m0_read;
   logic        m0_write;
   logic [7:0]  m0_rdata;
   logic        m0_wait;

   logic [15:0] m1_addr;
   logic [7:0]  m1_wdata;
   logic        m1_read;
   logic        m1_write;
   logic [7:0]  m1_rdata;
   logic        m1_wait;

   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   logic        timeout_err;

   modport slave (
      input  m0_addr, m0_wdata, m0_read, m0_write,
      output m0_rdata, m0_wait,
      input  m1_addr, m1_wdata, m1_read, m1_write,
      output m1_rdata, m1_wait,
      output mem_addr, mem_wdata, mem_req, mem_we,
      input  mem_rdata, mem_ready,
      output timeout_err
   );

   modport master (
      output m0_addr, m0_wdata, m0_read, m0_write,
      input  m0_rdata, m0_wait,
      output m1_addr, m1_wdata, m1_read, m1_write,
      input  m1_rdata, m1_wait,
      input  mem_addr, mem_wdata, mem_req, mem_we,
      output mem_rdata, mem_ready,
      input  timeout_err
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one memory port, with programmable wait
// states, a transaction timeout and per-master wait handshakes.
module bus_arbiter #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_r, state_s;
   logic        grant_r, grant_s;
   logic        last_grant_r, last_grant_s;
   logic [15:0] addr_r, addr_s;
   logic [7:0]  wdata_r, wdata_s;
   logic        we_r, we_s;
   logic        mem_req_r, mem_req_s;
   logic [3:0]  ws_cnt_r, ws_cnt_s;
   logic [7:0]  to_cnt_r, to_cnt_s;
   logic [7:0]  m0_rdata_r, m0_rdata_s;
   logic [7:0]  m1_rdata_r, m1_rdata_s;
   logic        timeout_err_r, timeout_err_s;

   logic        req0_s, req1_s;
   logic        complete_s, expired_s;

   assign req0_s = bus.m0_read | bus.m0_write;
   assign req1_s = bus.m1_read | bus.m1_write;

   // A requester is released only during the DONE cycle of its own grant.
   assign bus.m0_wait = req0_s & ~((state_r == DONE) & (grant_r == 1'b0));
   assign bus.m1_wait = req1_s & ~((state_r == DONE) & (grant_r == 1'b1));

   assign complete_s = (ws_cnt_r == 4'd0) & bus.mem_ready;
   assign expired_s  = (to_cnt_r == TO_LAST);

   // Next-state and datapath decode for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      state_s       = state_r;
      grant_s       = grant_r;
      last_grant_s  = last_grant_r;
      addr_s        = addr_r;
      wdata_s       = wdata_r;
      we_s          = we_r;
      mem_req_s     = mem_req_r;
      ws_cnt_s      = ws_cnt_r;
      to_cnt_s      = to_cnt_r;
      m0_rdata_s    = m0_rdata_r;
      m1_rdata_s    = m1_rdata_r;
      timeout_err_s = 1'b0;

      case (state_r)
         IDLE: begin
            if (req0_s | req1_s) begin
               // On contention the master that did not win last time goes first.
               if (req0_s & req1_s) begin
                  grant_s = ~last_grant_r;
               end else begin
                  grant_s = req1_s;
               end
               if (grant_s) begin
                  addr_s  = bus.m1_addr;
                  wdata_s = bus.m1_wdata;
                  we_s    = bus.m1_write;
               end else begin
                  addr_s  = bus.m0_addr;
                  wdata_s = bus.m0_wdata;
                  we_s    = bus.m0_write;
               end
               ws_cnt_s  = WS_INIT;
               to_cnt_s  = 8'd0;
               mem_req_s = 1'b1;
               state_s   = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end

         ACCESS: begin
            to_cnt_s = to_cnt_r + 8'd1;
            if (ws_cnt_r != 4'd0) begin
               ws_cnt_s = ws_cnt_r - 4'd1;
            end else begin
               ws_cnt_s = ws_cnt_r;
            end
            if (complete_s) begin
               if (!we_r) begin
                  if (grant_r) begin
                     m1_rdata_s = bus.mem_rdata;
                  end else begin
                     m0_rdata_s = bus.mem_rdata;
                  end
               end else begin
                  m0_rdata_s = m0_rdata_r;
               end
               mem_req_s = 1'b0;
               we_s      = 1'b0;
               state_s   = DONE;
            end else if (expired_s) begin
               if (!we_r) begin
                  if (grant_r) begin
                     m1_rdata_s = 8'hFF;
                  end else begin
                     m0_rdata_s = 8'hFF;
                  end
               end else begin
                  m0_rdata_s = m0_rdata_r;
               end
               timeout_err_s = 1'b1;
               mem_req_s     = 1'b0;
               we_s          = 1'b0;
               state_s       = DONE;
            end else begin
               state_s = ACCESS;
            end
         end

         DONE: begin
            last_grant_s = grant_r;
            mem_req_s    = 1'b0;
            state_s      = IDLE;
         end

         default: begin
            mem_req_s = 1'b0;
            we_s      = 1'b0;
            state_s   = IDLE;
         end
      endcase
   end

   // State and datapath registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         grant_r       <= 1'b0;
         last_grant_r  <= 1'b1;
         addr_r        <= 16'h0000;
         wdata_r       <= 8'h00;
         we_r          <= 1'b0;
         mem_req_r     <= 1'b0;
         ws_cnt_r      <= 4'd0;
         to_cnt_r      <= 8'd0;
         m0_rdata_r    <= 8'h00;
         m1_rdata_r    <= 8'h00;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         last_grant_r  <= last_grant_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         we_r          <= we_s;
         mem_req_r     <= mem_req_s;
         ws_cnt_r      <= ws_cnt_s;
         to_cnt_r      <= to_cnt_s;
         m0_rdata_r    <= m0_rdata_s;
         m1_rdata_r    <= m1_rdata_s;
         timeout_err_r <= timeout_err_s;
      end
   end

   assign bus.mem_addr    = addr_r;
   assign bus.mem_wdata   = wdata_r;
   assign bus.mem_we      = we_r;
   assign bus.mem_req     = mem_req_r;
   assign bus.m0_rdata    = m0_rdata_r;
   assign bus.m1_rdata    = m1_rdata_r;
   assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: single reads/writes, combined
// read+write, timeout, round-robin contention and reset during ACCESS.
module tb_bus_arbiter;
   localparam int WS = 1;
   localparam int TO = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] slave_xor;
   logic       slave_ready;
   int         checks   = 0;
   int         failures = 0;

   typedef struct {
      bit         m;
      logic [7:0] rdata;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_rd [2];

   bus_arbiter_if bus();

   bus_arbiter #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Slave returns a value derived from the address so each read is distinguishable.
   assign bus.mem_rdata = bus.mem_addr[7:0] ^ slave_xor;
   assign bus.mem_ready = slave_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=no-response expected=response-within-bound", tag);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit m, input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] wd);
      if (m) begin
         bus.m1_read = rd; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = wd;
      end else begin
         bus.m0_read = rd; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = wd;
      end
   endtask

   function automatic logic get_wait(input bit m);
      return m ? bus.m1_wait : bus.m0_wait;
   endfunction

   function automatic logic [7:0] get_rdata(input bit m);
      return m ? bus.m1_rdata : bus.m0_rdata;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      model_rd[0] = 8'h00;
      model_rd[1] = 8'h00;
      exp_q.delete();
   endtask

   // One transaction from a single master; expected result pushed when driven.
   task automatic run_txn(input bit m, input bit rd, input bit wr, input logic [15:0] a,
                          input logic [7:0] wd, input int exp_lat, input int exp_to);
      exp_t e;
      int   cyc = 0;
      int   to_seen = 0;
      bit   done = 1'b0;
      e.m = m;
      if (wr)          e.rdata = model_rd[m];
      else if (exp_to != 0) e.rdata = 8'hFF;
      else             e.rdata = a[7:0] ^ slave_xor;
      exp_q.push_back(e);
      model_rd[m] = e.rdata;
      drive(m, rd, wr, a, wd);
      #1;
      chk("stall_first_cycle", get_wait(m), 1);
      while (!done && cyc < exp_lat + 8) begin
         tick();
         cyc++;
         if (bus.timeout_err === 1'b1) to_seen++;
         if (get_wait(m) === 1'b0) begin
            done = 1'b1;
            e = exp_q.pop_front();
            chk("done_rdata", get_rdata(m), e.rdata);
            chk("other_rdata", get_rdata(!m), model_rd[!m]);
            chk("latency", cyc, exp_lat);
            chk("req_low_in_done", bus.mem_req, 0);
            chk("timeout_err_in_done", bus.timeout_err, exp_to);
            drive(m, 1'b0, 1'b0, a, wd);
         end else if (cyc < exp_lat) begin
            chk("access_req", bus.mem_req, 1);
            chk("access_addr", bus.mem_addr, a);
            chk("access_we", bus.mem_we, wr);
            if (wr) chk("access_wdata", bus.mem_wdata, wd);
         end
      end
      if (!done) begin
         bound_fail("txn_wait_release");
         drive(m, 1'b0, 1'b0, a, wd);
      end
      tick();
      if (bus.timeout_err === 1'b1) to_seen++;
      chk("timeout_pulses", to_seen, exp_to);
      chk("rdata_after_done", get_rdata(m), model_rd[m]);
   endtask

   // Both masters read in the same cycle; expected service order is queued up front.
   task automatic contend(input logic [15:0] a0, input logic [15:0] a1);
      exp_t e;
      int   cyc = 0;
      int   served = 0;
      bit   pend [2];
      e.m = 1'b0; e.rdata = a0[7:0] ^ slave_xor; exp_q.push_back(e); model_rd[0] = e.rdata;
      e.m = 1'b1; e.rdata = a1[7:0] ^ slave_xor; exp_q.push_back(e); model_rd[1] = e.rdata;
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      drive(1'b0, 1'b1, 1'b0, a0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, a1, 8'h00);
      #1;
      chk("contend_m0_stall", bus.m0_wait, 1);
      chk("contend_m1_stall", bus.m1_wait, 1);
      while (served < 2 && cyc < 20) begin
         tick();
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (pend[k] && get_wait(k[0]) === 1'b0) begin
               e = exp_q.pop_front();
               chk("contend_order", k, e.m);
               chk("contend_rdata", get_rdata(k[0]), e.rdata);
               chk("contend_cycle", cyc, (WS + 2) + served * (WS + 3));
               chk("contend_other_wait", get_wait(!k[0]), pend[1 - k]);
               pend[k] = 1'b0;
               drive(k[0], 1'b0, 1'b0, 16'h0000, 8'h00);
               served++;
            end
         end
      end
      if (served < 2) begin
         bound_fail("contend_service");
         drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
         drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      end
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      slave_xor   = 8'h6E;
      slave_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      model_rd[0] = 8'h00;
      model_rd[1] = 8'h00;
      tick();
      tick();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_m0_rdata", bus.m0_rdata, 0);
      chk("rst_m1_rdata", bus.m1_rdata, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      chk("rst_m0_wait", bus.m0_wait, 0);
      rst_n = 1'b1;
      tick();

      // m0 read of 0x1234 returns 0x5A and holds it.
      run_txn(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, WS + 2, 0);
      repeat (10) tick();
      chk("m0_rdata_hold", bus.m0_rdata, 8'h5A);

      // m1 write, then m0 read+write resolves to a write.
      run_txn(1'b1, 1'b0, 1'b1, 16'h8001, 8'hC3, WS + 2, 0);
      run_txn(1'b0, 1'b1, 1'b1, 16'h0010, 8'h77, WS + 2, 0);

      // Slave never ready: forced completion after TIMEOUT access cycles.
      slave_ready = 1'b0;
      run_txn(1'b0, 1'b1, 1'b0, 16'h4000, 8'h00, TO + 1, 1);
      slave_ready = 1'b1;
      run_txn(1'b1, 1'b1, 1'b0, 16'h2233, 8'h00, WS + 2, 0);

      // Contention straight after reset, twice: m0 first both times.
      do_reset();
      contend(16'h0101, 16'h0202);
      contend(16'h0303, 16'h0404);

      // Reset while in ACCESS abandons the transaction and clears read data.
      slave_ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 16'h5555, 8'h00);
      tick();
      chk("mid_access_req", bus.mem_req, 1);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h5555, 8'h00);
      tick();
      chk("mid_rst_req", bus.mem_req, 0);
      chk("mid_rst_m0_rdata", bus.m0_rdata, 0);
      chk("mid_rst_m1_rdata", bus.m1_rdata, 0);
      rst_n = 1'b1;
      model_rd[0] = 8'h00;
      model_rd[1] = 8'h00;
      exp_q.delete();
      slave_ready = 1'b1;
      tick();
      run_txn(1'b0, 1'b1, 1'b0, 16'h00AA, 8'h00, WS + 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
